// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder and its decode-side counterparts.
// Holds the FSM state encoding, the prefix opcode default and the instruction field layout.
package imm_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREF = 2'd1,
    ST_MAIN = 2'd2
  } enc_state_t;

  localparam logic [3:0] PREFIX_OP_DEFAULT = 4'hF;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned REG_W    = 2;
  localparam int unsigned REG_LSB  = 10;
  localparam int unsigned IMM12_W  = 12;
  localparam int unsigned IMM10_W  = 10;
  localparam int unsigned LOW_W    = 4;
  localparam int unsigned PREFIX_W = 12;

  // True when the top bits above a signed field of width w are pure sign copies.
  function automatic logic fits_signed(input logic [WORD_W-1:0] value,
                                       input int unsigned w);
    logic all_one;
    logic all_zero;
    all_one  = 1'b1;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (i >= w - 1) begin
        all_one  = all_one  & value[i];
        all_zero = all_zero & ~value[i];
      end
    end
    return all_one | all_zero;
  endfunction

endpackage

// File: rtl/imm_encoder_fit_check.sv
// Combinational fit test and word formation for one encode request.
// main_word is the single fitting word, or the low-nibble word that follows a prefix.
module imm_fit_check
  import imm_encoder_pkg::*;
#(
  parameter logic [3:0] PREFIX_OP = PREFIX_OP_DEFAULT
) (
  input  logic [15:0] value,
  input  logic        imSlct,
  input  logic [3:0]  op,
  input  logic [1:0]  reg_field,
  output logic        fits,
  output logic [15:0] main_word,
  output logic [15:0] prefix_word
);

  logic fits12;
  logic fits10;

  assign fits12 = fits_signed(value, IMM12_W);
  assign fits10 = fits_signed(value, IMM10_W);

  always_comb begin
    fits        = imSlct ? fits10 : fits12;
    prefix_word = {PREFIX_OP, value[WORD_W-1:LOW_W]};
    main_word   = '0;
    main_word[WORD_W-1:OP_LSB] = op;
    if (imSlct) begin
      main_word[OP_LSB-1:REG_LSB] = reg_field;
      if (fits10) begin
        main_word[IMM10_W-1:0] = value[IMM10_W-1:0];
      end else begin
        main_word[LOW_W-1:0] = value[LOW_W-1:0];
      end
    end else begin
      if (fits12) begin
        main_word[IMM12_W-1:0] = value[IMM12_W-1:0];
      end else begin
        main_word[LOW_W-1:0] = value[LOW_W-1:0];
      end
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: turns a signed value plus opcode/register fields into one
// instruction word, or a prefix word followed by a main word when the value does not fit.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter logic [3:0]  PREFIX_OP = PREFIX_OP_DEFAULT,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_value,
  input  logic [3:0]       in_op,
  input  logic [1:0]       in_reg,
  input  logic             imSlct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_word,
  output logic             out_last,
  output logic [CNT_W-1:0] prefix_cnt,
  output logic             op_err
);

  enc_state_t  state;
  logic [15:0] held_main;
  logic        fits;
  logic [15:0] main_word;
  logic [15:0] prefix_word;
  logic        in_xfer;

  imm_fit_check #(
    .PREFIX_OP(PREFIX_OP)
  ) u_fit (
    .value      (in_value),
    .imSlct     (imSlct),
    .op         (in_op),
    .reg_field  (in_reg),
    .fits       (fits),
    .main_word  (main_word),
    .prefix_word(prefix_word)
  );

  // A new request may enter while the last word of the previous one drains.
  assign in_ready = (state == ST_IDLE) || ((state == ST_MAIN) && out_ready);
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_word   <= 16'h0000;
      out_last   <= 1'b0;
      held_main  <= 16'h0000;
      prefix_cnt <= '0;
      op_err     <= 1'b0;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        if (in_op == PREFIX_OP) begin
          op_err <= 1'b1;
        end
        if (fits) begin
          state    <= ST_MAIN;
          out_word <= main_word;
          out_last <= 1'b1;
        end else begin
          state     <= ST_PREF;
          out_word  <= prefix_word;
          out_last  <= 1'b0;
          held_main <= main_word;
          if (prefix_cnt != {CNT_W{1'b1}}) begin
            prefix_cnt <= prefix_cnt + CNT_W'(1);
          end
        end
      end else begin
        case (state)
          ST_PREF: begin
            if (out_ready) begin
              state    <= ST_MAIN;
              out_word <= held_main;
              out_last <= 1'b1;
            end
          end
          ST_MAIN: begin
            if (out_ready) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
            end
          end
          default: begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Immediate encoder for the 16-bit processor: the write-side counterpart of the decode-stage sign extender. It accepts a 16-bit signed value plus opcode and register fields, and checks whether the value fits the selected immediate field: 12-bit for imSlct=0, 10-bit for imSlct=1. If it fits, the block emits one instruction word. If not, it emits a prefix word followed by the main word. It sits between the instruction-generation logic (loader/assembler path) and instruction memory write port, with valid/ready handshakes on both sides.

## Interface
Parameters:
- PREFIX_OP, 4'hF, opcode used for the prefix word
- CNT_W, 8, width of saturating prefix counter

Ports:
- CLK  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising CLK edge resets the block
- in_valid  in  1  input word offered
- in_ready  out  1  block can accept this cycle
- in_value  in  16  signed value to encode
- in_op  in  4  opcode of the main word
- in_reg  in  2  register field, used only when imSlct=1
- imSlct  in  1  0: 12-bit immediate field; 1: 10-bit immediate field
- out_valid  out  1  out_word holds a word
- out_ready  in  1  consumer takes word this cycle
- out_word  out  16  encoded instruction word
- out_last  out  1  1 on main word, 0 on prefix word
- prefix_cnt  out  CNT_W  number of prefixed encodes, saturating
- op_err  out  1  sticky; set when in_op==PREFIX_OP is accepted

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Fit test:
  - imSlct=0: fits iff in_value[15:11] are all equal (range -2048..2047).
  - imSlct=1: fits iff in_value[15:9] are all equal (range -512..511).
- Fits, single main word:
  - imSlct=0: {in_op, in_value[11:0]}
  - imSlct=1: {in_op, in_reg, in_value[9:0]}
- Does not fit, two words:
  - Prefix word first: {PREFIX_OP, in_value[15:4]}.
  - Then main word: imSlct=0: {in_op, 8'h00, in_value[3:0]}; imSlct=1: {in_op, in_reg, 6'b0, in_value[3:0]}.
  - The decoder rebuilds the value as {prefix[11:0], main[3:0]}.
- FSM states:
  - IDLE: out_valid=0.
  - PREF: out_word=prefix, out_last=0.
  - MAIN: out_word=main, out_last=1.
- Transitions:
  - IDLE + input transfer: go to MAIN if the value fits, else PREF.
  - PREF + out_ready: go to MAIN, loading the held main word.
  - MAIN + out_ready: go to MAIN or PREF if an input transfer happens the same cycle, else IDLE.
- in_ready = (state==IDLE) || (state==MAIN && out_ready). It is 0 in PREF.
- Main-word fields (in_op, in_reg, low bits, imSlct) are captured at input transfer. Input signals are don't-care after that.
- prefix_cnt increments by 1 on each accepted non-fitting input and holds at all-ones.
- op_err is set on any accepted input with in_op==PREFIX_OP. The words are still emitted unchanged.

## Timing
- Latency: the first word is valid the cycle after input transfer.
- Throughput: fitting inputs sustain 1 word/cycle while out_ready=1. A non-fitting input costs 2 output cycles.
- out_word and out_last are held stable while out_valid && !out_ready (no change under backpressure).
- Reset (reset==0 at an edge): state=IDLE, out_valid=0, out_word=16'h0000, out_last=0, prefix_cnt=0, op_err=0, in_ready=1 from the first cycle after reset.
- Reset mid-sequence (in PREF or MAIN): pending words are discarded and never emitted.
- Boundaries:
  - Values exactly at the range limits (2047/-2048, 511/-512) fit.
  - 2048 and -2049 are prefixed under imSlct=0.
  - 512 and -513 are prefixed under imSlct=1.
- All outputs are registered except in_ready, which is a combinational function of state and out_ready.

## Structure
- Shared package holds: state encoding (IDLE/PREF/MAIN), PREFIX_OP default, field position constants (opcode [15:12], reg [11:10], imm12 [11:0], imm10 [9:0]). The sign extender and decoder use the same constants.
- One natural sub-module: imm_fit_check, combinational. Inputs: value, imSlct. Outputs: fits, main_word, prefix_word.
- Top level: FSM, output register, held main word, counter, error flag.

## Test plan
- Fit, imSlct=0: value=16'h07FF, op=4'h2, out_ready=1 -> one word 16'h27FF, out_last=1, prefix_cnt stays 0.
- Prefix, imSlct=0: value=16'h0800, op=4'h3 -> words 16'hF080 (out_last=0), then 16'h3000 (out_last=1); prefix_cnt=1; in_ready=0 during PREF.
- imSlct=1, negative: value=16'hFE00 (-512), reg=2'b10, op=4'h5 -> 16'h5A00. Value=16'hFDFF (-513) -> 16'hFFDF, then 16'h580F.
- Backpressure: hold out_ready=0 for 3 cycles in PREF -> out_word stays 16'hF080 and no input is accepted. Then back-to-back fitting inputs with out_ready=1 -> one word per cycle.
- Reset mid-op: assert reset=0 while in PREF -> next cycle out_valid=0, prefix_cnt=0, and the main word is never emitted.
- Saturation and error: 260 non-fitting inputs -> prefix_cnt=8'hFF. Input with op=4'hF -> op_err=1, stays set until reset.
